// File: rtl/spi_pkg.sv
// Shared types and width helpers for the SPI command link (serializer and deserializer).
package spi_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SKIP,
        SHIFT
    } state_t;

    localparam int OPCODEW = 2;
    localparam int ADDRW   = 8;
    localparam int DATAW   = 8;

    // Bits needed to hold a counter that runs 0..max_val, never narrower than 1.
    function automatic int cnt_w(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/spi_rx_buf.sv
// Two-entry FIFO between the SPI shifter and a valid/ready consumer.
// Words arriving while full are dropped and latch a sticky overflow flag.
module spi_rx_buf #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         ready_in,
    output logic [W-1:0] data_out,
    output logic         valid_out,
    output logic         full,
    output logic         overflow
);

    logic [W-1:0] head_q, head_d;
    logic [W-1:0] tail_q, tail_d;
    logic [1:0]   count_q, count_d;
    logic         ovf_q, ovf_d;
    logic         pop;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        pop     = (count_q != 2'd0) && ready_in;
        case ({push, pop})
            2'b10: begin
                case (count_q)
                    2'd0: begin
                        head_d  = push_data;
                        count_d = 2'd1;
                    end
                    2'd1: begin
                        tail_d  = push_data;
                        count_d = 2'd2;
                    end
                    default: ovf_d = 1'b1;
                endcase
            end
            2'b01: begin
                if (count_q == 2'd2) begin
                    head_d = tail_q;
                end
                count_d = count_q - 2'd1;
            end
            2'b11: begin
                // Occupancy is unchanged: the popped head is replaced in order.
                if (count_q == 2'd2) begin
                    head_d = tail_q;
                    tail_d = push_data;
                end else begin
                    head_d = push_data;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= 2'd0;
            ovf_q   <= 1'b0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    assign data_out  = head_q;
    assign valid_out = (count_q != 2'd0);
    assign full      = (count_q == 2'd2);
    assign overflow  = ovf_q;

endmodule

// File: rtl/spi_deserializer.sv
// Receive side of the SPI command link: skips opcode+address, assembles MSB-first words.
// Define SPI_DESER_PARITY_EN to expect a trailing even-parity bit after each word.
module spi_deserializer #(
    parameter int OPCODEW   = spi_pkg::OPCODEW,
    parameter int ADDRW     = spi_pkg::ADDRW,
    parameter int SKIP_BITS = OPCODEW + ADDRW,
    parameter int DATAW     = spi_pkg::DATAW
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             n_cs,
    input  logic             spi_clk,
    input  logic             miso,
    output logic [DATAW-1:0] data_out,
    output logic             valid_out,
    input  logic             ready_in,
    output logic             frame_err,
    output logic             overflow,
    output logic             parity_err
);

    import spi_pkg::*;

    localparam int SKW = cnt_w(SKIP_BITS);
    localparam int BCW = cnt_w(DATAW);

    localparam logic [SKW-1:0] SKIP_LAST = SKW'(SKIP_BITS - 1);
`ifdef SPI_DESER_PARITY_EN
    localparam logic [BCW-1:0] PAR_BIT   = BCW'(DATAW);
`else
    localparam logic [BCW-1:0] DATA_LAST = BCW'(DATAW - 1);
`endif

    logic             spi_clk_q, n_cs_q;
    logic             rise, start, stop;
    state_t           state_q, state_d;
    logic [SKW-1:0]   skip_cnt_q, skip_cnt_d;
    logic [BCW-1:0]   bit_cnt_q, bit_cnt_d;
    logic [DATAW-1:0] shreg_q, shreg_d;
    logic             frame_err_q, frame_err_d;
    logic             parity_err_q, parity_err_d;
    logic             push;
    logic [DATAW-1:0] push_data;
    logic             buf_full_unused;

    // n_cs_q resets low so a frame already running at reset release is not picked up.
    assign rise  = spi_clk & ~spi_clk_q;
    assign start = ~n_cs & n_cs_q;
    assign stop  = n_cs & ~n_cs_q;

    always_comb begin
        state_d      = state_q;
        skip_cnt_d   = skip_cnt_q;
        bit_cnt_d    = bit_cnt_q;
        shreg_d      = shreg_q;
        frame_err_d  = 1'b0;
        parity_err_d = 1'b0;
        push         = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    skip_cnt_d = '0;
                    bit_cnt_d  = '0;
                    if (SKIP_BITS == 0) state_d = SHIFT;
                    else                state_d = SKIP;
                end
            end
            SKIP: begin
                if (stop) begin
                    state_d = IDLE;
                end else if (rise) begin
                    if (skip_cnt_q == SKIP_LAST) begin
                        skip_cnt_d = '0;
                        state_d    = SHIFT;
                    end else begin
                        skip_cnt_d = skip_cnt_q + 1'b1;
                    end
                end
            end
            SHIFT: begin
                if (stop) begin
                    state_d     = IDLE;
                    bit_cnt_d   = '0;
                    frame_err_d = (bit_cnt_q != '0);
                end else if (rise) begin
`ifdef SPI_DESER_PARITY_EN
                    if (bit_cnt_q == PAR_BIT) begin
                        bit_cnt_d = '0;
                        if ((^shreg_q) == miso) push = 1'b1;
                        else                    parity_err_d = 1'b1;
                    end else begin
                        shreg_d   = {shreg_q[DATAW-2:0], miso};
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
`else
                    shreg_d = {shreg_q[DATAW-2:0], miso};
                    if (bit_cnt_q == DATA_LAST) begin
                        bit_cnt_d = '0;
                        push      = 1'b1;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
`endif
                end
            end
            default: state_d = IDLE;
        endcase
        push_data = shreg_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            spi_clk_q    <= 1'b0;
            n_cs_q       <= 1'b0;
            state_q      <= IDLE;
            skip_cnt_q   <= '0;
            bit_cnt_q    <= '0;
            shreg_q      <= '0;
            frame_err_q  <= 1'b0;
            parity_err_q <= 1'b0;
        end else begin
            spi_clk_q    <= spi_clk;
            n_cs_q       <= n_cs;
            state_q      <= state_d;
            skip_cnt_q   <= skip_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            shreg_q      <= shreg_d;
            frame_err_q  <= frame_err_d;
            parity_err_q <= parity_err_d;
        end
    end

    spi_rx_buf #(.W(DATAW)) u_buf (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_data),
        .ready_in  (ready_in),
        .data_out  (data_out),
        .valid_out (valid_out),
        .full      (buf_full_unused),
        .overflow  (overflow)
    );

    assign frame_err = frame_err_q;
`ifdef SPI_DESER_PARITY_EN
    assign parity_err = parity_err_q;
`else
    assign parity_err = 1'b0;
`endif

endmodule
